next_value_gen: RTL and testbench
=================================

# next_value_gen

Parametrised successor to the team's fixed constant-value `next` source. It presents a WIDTH-bit value stream on `next` with a valid/ready handshake. Each stream runs in one of four modes: constant, wrapping counter, modulo counter, or Galois LFSR. The stream can be reloaded at runtime. It feeds the downstream datapath wherever a seed, index or step value is consumed once per transaction. With the default parameters in constant mode, it reproduces the legacy behaviour: 64-bit `next` = 1.

## Interface
Parameters:
- `WIDTH`, 64: width of `next` and `load_value`.
- `INIT_VALUE`, 1: reset value of `next`; the constant-mode output.
- `STEP`, 1: increment for count modes; must satisfy `STEP` < `MOD_LIMIT`.
- `MOD_LIMIT`, 1000: modulus for modulo mode; values run 0..`MOD_LIMIT`-1.
- `LFSR_TAPS`, 64'hD800_0000_0000_0000: right-shift Galois tap mask.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  allow the stream to present values.
- `mode`  in  2  0 CONST, 1 COUNT, 2 MOD, 3 LFSR.
- `load`  in  1  load `load_value` this cycle.
- `load_value`  in  WIDTH  value to load.
- `next`  out  WIDTH  current stream value (reg).
- `next_valid`  out  1  `next` is offered.
- `next_ready`  in  1  consumer accepts `next`.
- `wrapped`  out  1  one-cycle pulse: the last advance wrapped.

## Operation
- States: EMPTY (`next_valid`=0) and FULL (`next_valid`=1).
- Reset values: `next`=`INIT_VALUE`, state EMPTY, `wrapped`=0.
- Transfer is defined as `next_valid` & `next_ready`.
- EMPTY & `enable`: go to FULL. `next` is unchanged, so the current value is offered first.
- FULL & transfer: advance `next` to its successor. State becomes FULL if `enable`, else EMPTY. Each value is delivered exactly once.
- FULL & !transfer: hold `next` and `next_valid` stable. The value never changes while it is offered.
- `load` has priority over everything else:
  - `next` <= `load_value`, state <= FULL, `wrapped` <= 0.
  - If a transfer occurs in the same cycle, that value counts as consumed; the loaded value replaces it and no advance happens.
- Successor function, chosen by `mode` sampled at the advance edge:
  - CONST: successor = `INIT_VALUE`; wrap = 0.
  - COUNT: sum = `next` + `STEP` in WIDTH+1 bits; successor = low WIDTH bits; wrap = carry bit.
  - MOD: s = `next` + `STEP` in WIDTH+1 bits. If s >= `MOD_LIMIT`, successor = s − `MOD_LIMIT` and wrap = 1; otherwise successor = s and wrap = 0. A loaded value >= `MOD_LIMIT` is taken as-is; the first advance subtracts once.
  - LFSR: if `next`[0], successor = (`next` >> 1) ^ `LFSR_TAPS`, else successor = `next` >> 1. If `next` == 0, successor = 1 (lock-up escape). wrap = 0.
- `wrapped` is registered and equals the wrap flag of the advance at the previous edge; 0 on every other cycle.
- A `mode` change has no effect until the next advance; it never alters a value already offered.

## Timing
- Latency from `enable` rising (in EMPTY) to `next_valid`=1: 1 cycle.
- Throughput: one value per cycle while `enable`=`next_ready`=1.
- Advanced value and `wrapped` appear one cycle after the transfer edge.
- `load` result is visible one cycle after the `load` edge, with `next_valid`=1.
- `rst` asserted mid-stream forces all outputs to reset values immediately, independent of `clk`. Release is synchronised externally; the first operating edge after release behaves as EMPTY.

## Structure
- Shared package `next_gen_pkg`:
  - mode encoding constants `MODE_CONST`, `MODE_COUNT`, `MODE_MOD`, `MODE_LFSR`;
  - state typedef (EMPTY, FULL);
  - default `LFSR_TAPS` constant.
- One combinational sub-module, `next_gen_step`: inputs value and mode; outputs successor and wrap flag. The top holds only the state, `next` register, load priority and `wrapped` register.

## Test plan
- Defaults, mode 0, `enable`=`next_ready`=1 after reset -> `next_valid` rises 1 cycle later; `next`=1 on every cycle; `wrapped` never set.
- WIDTH=8, mode 1, load 8'hFE, ready=1 -> `next` sequence FE, FF, 00, 01; `wrapped`=1 only in the cycle `next`=00.
- WIDTH=8, MOD_LIMIT=10, STEP=3, mode 2, load 0 -> sequence 0, 3, 6, 9, 2, 5; `wrapped` pulses with 2.
- Backpressure: FULL with `next`=6, `next_ready`=0 for 5 cycles -> `next`=6 and `next_valid`=1 held; `next_ready`=1 for one cycle -> `next`=9 next cycle. Dropping `enable` on that transfer -> EMPTY with `next`=9.
- WIDTH=8, TAPS=8'hB8, mode 3, load 1 -> sequence 01, B8, 5C, 2E, 17, B3. Load 0 -> following value 01.
- Load during transfer and async reset: `load`=1 with value 8'h55 while `next`=6 and ready=1 -> next cycle `next`=55, valid. `rst` pulsed between edges -> `next`=`INIT_VALUE` and `next_valid`=0 immediately.

Source files
------------

// File: rtl/next_gen_pkg.sv
// Shared definitions for the next-value stream source: mode encoding,
// handshake state and the default LFSR tap mask.
package next_gen_pkg;

  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_COUNT = 2'd1;
  localparam logic [1:0] MODE_MOD   = 2'd2;
  localparam logic [1:0] MODE_LFSR  = 2'd3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [63:0] LFSR_TAPS_DEFAULT = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/next_gen_step.sv
// Combinational successor function for the next-value stream.
// Given the current value and mode, produces the following value and
// whether producing it wrapped around.
module next_gen_step
  import next_gen_pkg::*;
#(
  parameter int unsigned      WIDTH      = 64,
  parameter logic [WIDTH-1:0] INIT_VALUE = WIDTH'(1),
  parameter logic [WIDTH-1:0] STEP       = WIDTH'(1),
  parameter logic [WIDTH-1:0] MOD_LIMIT  = WIDTH'(1000),
  parameter logic [WIDTH-1:0] LFSR_TAPS  = WIDTH'(LFSR_TAPS_DEFAULT)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] succ,
  output logic             wrap
);

  // Carry-extended sum shared by the two counting modes.
  logic [WIDTH:0]   sum;
  // The reduced value always fits in WIDTH bits because STEP < MOD_LIMIT,
  // so the subtraction can be done modulo 2^WIDTH.
  logic [WIDTH-1:0] mod_reduced;

  assign sum         = {1'b0, value} + {1'b0, STEP};
  assign mod_reduced = sum[WIDTH-1:0] - MOD_LIMIT;

  // Select the successor for the requested mode.
  always_comb begin
    succ = value;
    wrap = 1'b0;
    case (mode)
      MODE_CONST: succ = INIT_VALUE;
      MODE_COUNT: begin
        succ = sum[WIDTH-1:0];
        wrap = sum[WIDTH];
      end
      MODE_MOD: begin
        // A loaded value above the limit is reduced only once per advance.
        if (sum >= {1'b0, MOD_LIMIT}) begin
          succ = mod_reduced;
          wrap = 1'b1;
        end else begin
          succ = sum[WIDTH-1:0];
        end
      end
      MODE_LFSR: begin
        // All-zero is the LFSR lock-up state; escape it to 1.
        if (value == '0)    succ = WIDTH'(1);
        else if (value[0])  succ = (value >> 1) ^ LFSR_TAPS;
        else                succ = value >> 1;
      end
      default: succ = value;
    endcase
  end

endmodule

// File: rtl/next_value_gen.sv
// Parametrised next-value stream source with valid/ready handshake.
// Holds the offered value, the EMPTY/FULL handshake state, load priority
// and the registered wrap pulse; the successor math lives in next_gen_step.
module next_value_gen
  import next_gen_pkg::*;
#(
  parameter int unsigned      WIDTH      = 64,
  parameter logic [WIDTH-1:0] INIT_VALUE = WIDTH'(1),
  parameter logic [WIDTH-1:0] STEP       = WIDTH'(1),
  parameter logic [WIDTH-1:0] MOD_LIMIT  = WIDTH'(1000),
  parameter logic [WIDTH-1:0] LFSR_TAPS  = WIDTH'(LFSR_TAPS_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] next,
  output logic             next_valid,
  input  logic             next_ready,
  output logic             wrapped
);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] next_n;
  logic             wrapped_n;
  logic [WIDTH-1:0] succ;
  logic             wrap;
  logic             xfer;

  next_gen_step #(
    .WIDTH      (WIDTH),
    .INIT_VALUE (INIT_VALUE),
    .STEP       (STEP),
    .MOD_LIMIT  (MOD_LIMIT),
    .LFSR_TAPS  (LFSR_TAPS)
  ) u_step (
    .value (next),
    .mode  (mode),
    .succ  (succ),
    .wrap  (wrap)
  );

  assign next_valid = (state == FULL);
  assign xfer       = next_valid & next_ready;

  // Register handshake state, offered value and wrap pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      next    <= INIT_VALUE;
      wrapped <= 1'b0;
    end else begin
      state   <= state_n;
      next    <= next_n;
      wrapped <= wrapped_n;
    end
  end

  // Next-state logic: load wins, otherwise fill when enabled and advance
  // only on a transfer so an offered value never changes.
  always_comb begin
    state_n   = state;
    next_n    = next;
    wrapped_n = 1'b0;
    if (load) begin
      // A same-cycle transfer consumes the old value; no advance happens.
      next_n  = load_value;
      state_n = FULL;
    end else begin
      case (state)
        EMPTY: begin
          if (enable) state_n = FULL;
        end
        FULL: begin
          if (xfer) begin
            next_n    = succ;
            wrapped_n = wrap;
            state_n   = enable ? FULL : EMPTY;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_next_value_gen.sv
// Scoreboard bench for next_value_gen: a default 64-bit instance in constant
// mode and an 8-bit instance (STEP=3, MOD_LIMIT=10, taps B8) for the other
// modes, backpressure, load-during-transfer and asynchronous reset.
module tb_next_value_gen;

  typedef struct packed {
    logic [7:0] val;
    logic       wrp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  // Default-parameter instance.
  logic        d_enable, d_load, d_ready;
  logic [1:0]  d_mode;
  logic [63:0] d_load_value, d_next;
  logic        d_valid, d_wrapped;

  // 8-bit instance.
  logic        u_enable, u_load, u_ready;
  logic [1:0]  u_mode;
  logic [7:0]  u_load_value, u_next;
  logic        u_valid, u_wrapped;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  next_value_gen u_def (
    .clk        (clk),
    .rst        (rst),
    .enable     (d_enable),
    .mode       (d_mode),
    .load       (d_load),
    .load_value (d_load_value),
    .next       (d_next),
    .next_valid (d_valid),
    .next_ready (d_ready),
    .wrapped    (d_wrapped)
  );

  next_value_gen #(
    .WIDTH      (8),
    .INIT_VALUE (8'h01),
    .STEP       (8'd3),
    .MOD_LIMIT  (8'd10),
    .LFSR_TAPS  (8'hB8)
  ) u_w8 (
    .clk        (clk),
    .rst        (rst),
    .enable     (u_enable),
    .mode       (u_mode),
    .load       (u_load),
    .load_value (u_load_value),
    .next       (u_next),
    .next_valid (u_valid),
    .next_ready (u_ready),
    .wrapped    (u_wrapped)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] v, input logic w);
    exp_t e;
    e.val = v;
    e.wrp = w;
    sb.push_back(e);
  endtask

  // Load v in mode m, then accept n values back to back; ends with ready low.
  task automatic load_run(input logic [7:0] v, input logic [1:0] m, input int n);
    u_load = 1'b1; u_load_value = v; u_mode = m; u_ready = 1'b0; u_enable = 1'b1;
    @(posedge clk); #1;
    u_load = 1'b0; u_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1 u_ready = 1'b0;
  endtask

  // Monitor: every transfer on the 8-bit instance pops one expectation.
  always @(negedge clk) begin
    if (!rst && u_valid && u_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_xfer: got %h with no expectation queued", u_next);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("w8_next", {56'd0, u_next}, {56'd0, e.val});
        chk("w8_wrapped", {63'd0, u_wrapped}, {63'd0, e.wrp});
      end
    end
  end

  // Monitor: the default constant stream always offers 1 with no wrap.
  always @(negedge clk) begin
    if (!rst && d_valid) begin
      chk("def_next", d_next, 64'd1);
      chk("def_wrapped", {63'd0, d_wrapped}, 64'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    d_enable = 0; d_load = 0; d_ready = 0; d_mode = 2'd0; d_load_value = '0;
    u_enable = 0; u_load = 0; u_ready = 0; u_mode = 2'd0; u_load_value = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_def_valid", {63'd0, d_valid}, 64'd0);
    chk("rst_def_next", d_next, 64'd1);
    chk("rst_w8_valid", {63'd0, u_valid}, 64'd0);
    chk("rst_w8_next", {56'd0, u_next}, 64'h01);
    chk("rst_w8_wrapped", {63'd0, u_wrapped}, 64'd0);
    rst = 1'b0;

    // Constant mode, default parameters: valid one cycle after enable.
    @(posedge clk); #1;
    d_enable = 1'b1; d_ready = 1'b1;
    chk("def_latency_before", {63'd0, d_valid}, 64'd0);
    @(posedge clk); #1;
    chk("def_latency_after", {63'd0, d_valid}, 64'd1);
    repeat (5) @(posedge clk);
    #1 d_enable = 1'b0;

    // Wrapping counter: FE + 3 carries out to 01.
    push(8'hFE, 0); push(8'h01, 1); push(8'h04, 0); push(8'h07, 0);
    load_run(8'hFE, 2'd1, 4);

    // Modulo counter, stop with 6 offered.
    push(8'h00, 0); push(8'h03, 0);
    load_run(8'h00, 2'd2, 2);

    // Backpressure: 6 must hold for five cycles.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_next", {56'd0, u_next}, 64'h06);
      chk("hold_valid", {63'd0, u_valid}, 64'd1);
    end
    // One transfer with enable dropped: EMPTY holding 9.
    push(8'h06, 0);
    u_ready = 1'b1; u_enable = 1'b0;
    @(posedge clk); #1;
    u_ready = 1'b0;
    chk("drop_next", {56'd0, u_next}, 64'h09);
    chk("drop_valid", {63'd0, u_valid}, 64'd0);
    u_enable = 1'b1;
    @(posedge clk); #1;
    chk("refill_valid", {63'd0, u_valid}, 64'd1);
    chk("refill_next", {56'd0, u_next}, 64'h09);
    // Continue the modulo sequence through the wrap: 9, 2, 5.
    push(8'h09, 0); push(8'h02, 1); push(8'h05, 0);
    u_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 u_ready = 1'b0;

    // Galois LFSR with taps B8.
    push(8'h01, 0); push(8'hB8, 0); push(8'h5C, 0);
    push(8'h2E, 0); push(8'h17, 0); push(8'hB3, 0);
    load_run(8'h01, 2'd3, 6);
    // Lock-up escape: 00 is followed by 01.
    push(8'h00, 0); push(8'h01, 0);
    load_run(8'h00, 2'd3, 2);

    // Load during a transfer: 6 is consumed, 55 replaces it.
    push(8'h00, 0); push(8'h03, 0);
    load_run(8'h00, 2'd2, 2);
    push(8'h06, 0);
    u_ready = 1'b1; u_load = 1'b1; u_load_value = 8'h55;
    @(posedge clk); #1;
    u_load = 1'b0; u_ready = 1'b0;
    chk("load_xfer_next", {56'd0, u_next}, 64'h55);
    chk("load_xfer_valid", {63'd0, u_valid}, 64'd1);
    chk("load_xfer_wrapped", {63'd0, u_wrapped}, 64'd0);

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    chk("async_next", {56'd0, u_next}, 64'h01);
    chk("async_valid", {63'd0, u_valid}, 64'd0);
    chk("async_def_valid", {63'd0, d_valid}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    u_enable = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", {63'd0, u_valid}, 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
